// File: rtl/hit_accumulator_pkg.sv
// hit_accumulator_pkg: shared window-size default and accumulator state encoding
package hit_accumulator_pkg;
  localparam int LOG_N_DEFAULT = 5;
  typedef logic [1:0] state_t;
  localparam state_t S_WAIT_DAV     = 2'd0;
  localparam state_t S_WAIT_DAV_HI  = 2'd1;
  localparam state_t S_WAIT_ORFD_LO = 2'd2;
  localparam state_t S_WAIT_ORFD_HI = 2'd3;
endpackage

// File: rtl/hit_accumulator_dav_rfd_tx.sv
// dav_rfd_tx: registered producer side of a dav_/rfd handshake with its data register
module dav_rfd_tx #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         out_rfd_i,
  output logic         out_dav_o,
  output logic [W-1:0] out_data_o,
  output logic         lo_seen_o,
  output logic         done_o
);
  logic         busy_q;
  logic         dav_q;
  logic [W-1:0] data_q;
  assign lo_seen_o  = busy_q & ~dav_q & ~out_rfd_i;
  assign done_o     = busy_q & dav_q & out_rfd_i;
  assign out_dav_o  = dav_q;
  assign out_data_o = data_q;
  // load publishes data, consumer's rfd low withdraws dav_, rfd high again closes the transfer
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      dav_q  <= 1'b1;
      data_q <= '0;
    end else if (load_i) begin
      busy_q <= 1'b1;
      dav_q  <= 1'b0;
      data_q <= data_i;
    end else if (lo_seen_o) begin
      dav_q  <= 1'b1;
    end else if (done_o) begin
      busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/hit_accumulator.sv
// hit_accumulator: counts hits over 2^LOG_N verdicts and hands the total downstream; HANDSHAKE_TIMEOUT_EN adds a stuck-producer timeout and err
module hit_accumulator
  import hit_accumulator_pkg::*;
#(
  parameter int LOG_N = LOG_N_DEFAULT
`ifdef HANDSHAKE_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           dav_,
  input  logic           z,
  output logic           rfd,
  output logic           out_dav_,
  output logic [LOG_N:0] out_hits,
  input  logic           out_rfd
`ifdef HANDSHAKE_TIMEOUT_EN
  , output logic         err
`endif
);
  localparam logic [LOG_N:0] N = {1'b1, {LOG_N{1'b0}}};
  state_t         state_q, state_d;
  logic [LOG_N:0] hits_q, hits_d;
  logic [LOG_N:0] samples_q, samples_d;
  logic           rfd_q, rfd_d;
  logic           load, lo_seen, done;
`ifdef HANDSHAKE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          expired;
  assign expired = timer_q == TW'(TIMEOUT - 1);
  assign err     = err_q;
`endif
  assign rfd = rfd_q;
  dav_rfd_tx #(.W(LOG_N + 1)) u_tx (
    .clock     (clock),
    .reset     (reset),
    .load_i    (load),
    .data_i    (hits_q),
    .out_rfd_i (out_rfd),
    .out_dav_o (out_dav_),
    .out_data_o(out_hits),
    .lo_seen_o (lo_seen),
    .done_o    (done)
  );
  // input handshake, window counting and hand-off sequencing
  always_comb begin
    state_d   = state_q;
    hits_d    = hits_q;
    samples_d = samples_q;
    rfd_d     = rfd_q;
    load      = 1'b0;
`ifdef HANDSHAKE_TIMEOUT_EN
    timer_d   = '0;
    err_d     = err_q;
`endif
    case (state_q)
      S_WAIT_DAV:
        if (!dav_) begin
          hits_d    = hits_q + (LOG_N + 1)'(z);
          samples_d = samples_q + (LOG_N + 1)'(1);
          rfd_d     = 1'b0;
          state_d   = S_WAIT_DAV_HI;
        end
      S_WAIT_DAV_HI:
        if (dav_) begin
          if (samples_q != N) begin
            rfd_d   = 1'b1;
            state_d = S_WAIT_DAV;
          end else begin
            load    = 1'b1;
            state_d = S_WAIT_ORFD_LO;
          end
        end
`ifdef HANDSHAKE_TIMEOUT_EN
        else if (expired) begin
          err_d     = 1'b1;
          rfd_d     = 1'b1;
          hits_d    = '0;
          samples_d = '0;
          state_d   = S_WAIT_DAV;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      S_WAIT_ORFD_LO: state_d = lo_seen ? S_WAIT_ORFD_HI : state_q;
      S_WAIT_ORFD_HI:
        if (done) begin
          hits_d    = '0;
          samples_d = '0;
          rfd_d     = 1'b1;
          state_d   = S_WAIT_DAV;
        end
      default: state_d = S_WAIT_DAV;
    endcase
  end
  // state registers; reset aborts any window in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_WAIT_DAV;
      hits_q    <= '0;
      samples_q <= '0;
      rfd_q     <= 1'b1;
`ifdef HANDSHAKE_TIMEOUT_EN
      timer_q   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hits_q    <= hits_d;
      samples_q <= samples_d;
      rfd_q     <= rfd_d;
`ifdef HANDSHAKE_TIMEOUT_EN
      timer_q   <= timer_d;
      err_q     <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_hit_accumulator.sv
// tb_hit_accumulator: randomized producer/consumer bench with a window-sum scoreboard
module tb_hit_accumulator;
  import hit_accumulator_pkg::*;
  localparam int LOG_N = LOG_N_DEFAULT;
  localparam int N = 1 << LOG_N;
  logic clock = 0, reset = 1, dav_ = 1, z = 0, out_rfd = 1;
  logic rfd, out_dav_;
  logic [LOG_N:0] out_hits;
  int checks = 0, failures = 0;
  int exp_q[$];
  int win_hits = 0, win_cnt = 0;
  int hold = 0;
  logic prev_dav = 1;
`ifdef HANDSHAKE_TIMEOUT_EN
  logic err;
  hit_accumulator #(.LOG_N(LOG_N), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .dav_(dav_), .z(z), .rfd(rfd),
    .out_dav_(out_dav_), .out_hits(out_hits), .out_rfd(out_rfd), .err(err));
`else
  hit_accumulator #(.LOG_N(LOG_N)) dut (
    .clock(clock), .reset(reset), .dav_(dav_), .z(z), .rfd(rfd),
    .out_dav_(out_dav_), .out_hits(out_hits), .out_rfd(out_rfd));
`endif
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic zv);
    int t = 0;
    while (rfd !== 1'b1 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (rfd !== 1'b1) begin
      chk("rfd_wait_timeout", 0, 1);
      return;
    end
    dav_ = 0;
    z = zv;
    @(negedge clock);
    chk("rfd_fall", int'(rfd), 0);
    win_hits += int'(zv);
    win_cnt++;
    if (win_cnt == N) begin
      exp_q.push_back(win_hits);
      win_hits = 0;
      win_cnt = 0;
    end
    repeat ($urandom_range(0, 2)) @(negedge clock);
    dav_ = 1;
    z = 1'($urandom_range(0, 1));
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1;
    dav_ = 1;
    out_rfd = 1;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    win_hits = 0;
    win_cnt = 0;
    chk("reset_rfd", int'(rfd), 1);
    chk("reset_out_dav", int'(out_dav_), 1);
    chk("reset_out_hits", int'(out_hits), 0);
  endtask

  // downstream consumer: acknowledge each result after a random or forced delay
  initial forever begin
    @(negedge clock);
    if (!reset && out_dav_ === 1'b0) begin
      if (hold > 0) begin
        repeat (hold) begin
          chk("hold_out_dav", int'(out_dav_), 0);
          chk("hold_rfd", int'(rfd), 0);
          @(negedge clock);
        end
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      out_rfd = 0;
      for (int t = 0; t < 100 && out_dav_ !== 1'b1; t++) @(negedge clock);
      chk("out_dav_release", int'(out_dav_), 1);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      out_rfd = 1;
    end
  end

  // monitor: every falling out_dav_ must match the oldest expected window sum
  always @(negedge clock) begin
    if (reset) prev_dav = 1;
    else begin
      if (prev_dav === 1'b1 && out_dav_ === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got out_hits=%0d expected no result", out_hits);
        end else chk("out_hits", int'(out_hits), exp_q.pop_front());
      end
      prev_dav = out_dav_;
    end
  end

  initial begin
    logic [31:0] std_vec;
    std_vec = 32'hF7DE_B5A1;
    do_reset();
    for (int i = 0; i < N; i++) send(std_vec[i]);
    for (int i = 0; i < N; i++) send(1'b1);
    for (int i = 0; i < N; i++) send(1'b0);
    hold = 50;
    for (int i = 0; i < N; i++) send(1'($urandom_range(0, 1)));
    dav_ = 0;
    z = 1;
    repeat (40) begin
      chk("bp_rfd", int'(rfd), 0);
      @(negedge clock);
    end
    dav_ = 1;
    hold = 0;
    for (int i = 0; i < 10; i++) send(1'($urandom_range(0, 1)));
    do_reset();
    for (int i = 0; i < 3 * N; i++) send(1'($urandom_range(0, 1)));
    for (int t = 0; t < 200 && (exp_q.size() != 0 || out_dav_ !== 1'b1 || rfd !== 1'b1); t++)
      @(negedge clock);
    chk("pending_results", exp_q.size(), 0);
    chk("final_rfd", int'(rfd), 1);
`ifdef HANDSHAKE_TIMEOUT_EN
    do_reset();
    chk("err_reset", int'(err), 0);
    dav_ = 0;
    z = 1;
    @(negedge clock);
    chk("to_rfd_fall", int'(rfd), 0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 7) chk("err_before_timeout", int'(err), 0);
      if (k == 8) begin
        chk("err_at_timeout", int'(err), 1);
        chk("rfd_after_timeout", int'(rfd), 1);
      end
    end
    dav_ = 1;
    repeat (5) @(negedge clock);
    chk("err_sticky", int'(err), 1);
    chk("to_no_result", int'(out_dav_), 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
